// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - four-button short/long/repeat event detector with slot arbiter and 4-deep event FIFO
// Optional auto-repeat in HELD is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_event_arbiter #(
    parameter int F_COUNT      = 100_000,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_btn_lvl,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [1:0] o_evt_btn,
    output logic [1:0] o_evt_type,
    output logic [2:0] o_count,
    output logic       o_drop
);
    localparam int CW   = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
    localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(F_COUNT - 1);
    localparam logic [HW-1:0] LONG_V    = HW'(LONG_TICKS);
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [HW-1:0] REP_V     = HW'(REPEAT_TICKS);
`endif
    localparam logic [1:0] EV_SHORT  = 2'b01;
    localparam logic [1:0] EV_LONG   = 2'b10;
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [1:0] EV_REPEAT = 2'b11;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HELD} state_t;

    logic [CW-1:0] tick_cnt_q;
    logic          tick;
    state_t        state_q [4];
    state_t        state_d [4];
    logic [HW-1:0] hold_q  [4];
    logic [HW-1:0] hold_d  [4];
    logic [HW-1:0] hold_inc[4];
    logic [3:0]    raise;
    logic [1:0]    raise_type [4];
    logic [3:0]    slot_vld_q, slot_vld_d;
    logic [1:0]    slot_type_q[4];
    logic [1:0]    slot_type_d[4];
    logic [3:0]    mem_q [4];
    logic [1:0]    wr_ptr_q, rd_ptr_q;
    logic [2:0]    count_q;
    logic          drop_q, drop_d;
    logic          sel_vld, push, pop;
    logic [1:0]    sel_idx;
    logic [3:0]    head;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i]    = state_q[i];
            hold_d[i]     = hold_q[i];
            hold_inc[i]   = hold_q[i] + HW'(1);
            raise[i]      = 1'b0;
            raise_type[i] = EV_SHORT;
            case (state_q[i])
                ST_IDLE: begin
                    if (i_btn_lvl[i]) begin
                        state_d[i] = ST_PRESSED;
                        hold_d[i]  = '0;
                    end
                end
                ST_PRESSED: begin
                    // release takes priority over a coincident LONG tick
                    if (!i_btn_lvl[i]) begin
                        raise[i]      = 1'b1;
                        raise_type[i] = EV_SHORT;
                        state_d[i]    = ST_IDLE;
                    end else if (tick) begin
                        if (hold_inc[i] == LONG_V) begin
                            raise[i]      = 1'b1;
                            raise_type[i] = EV_LONG;
                            state_d[i]    = ST_HELD;
                            hold_d[i]     = '0;
                        end else begin
                            hold_d[i] = hold_inc[i];
                        end
                    end
                end
                ST_HELD: begin
                    if (!i_btn_lvl[i]) begin
                        state_d[i] = ST_IDLE;
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    else if (tick) begin
                        if (hold_inc[i] == REP_V) begin
                            raise[i]      = 1'b1;
                            raise_type[i] = EV_REPEAT;
                            hold_d[i]     = '0;
                        end else begin
                            hold_d[i] = hold_inc[i];
                        end
                    end
`endif
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slot_vld_q[i]) begin
                sel_vld = 1'b1;
                sel_idx = 2'(i);
            end
        end
        pop  = o_valid & i_ready;
        push = sel_vld & ((count_q != 3'd4) | pop);
        for (int i = 0; i < 4; i++) begin
            slot_vld_d[i]  = slot_vld_q[i];
            slot_type_d[i] = slot_type_q[i];
            if (push && (sel_idx == 2'(i))) begin
                slot_vld_d[i] = 1'b0;
            end
            // an occupied slot keeps its event; the new one is lost
            if (raise[i] && !slot_vld_q[i]) begin
                slot_vld_d[i]  = 1'b1;
                slot_type_d[i] = raise_type[i];
            end
        end
        drop_d = |(raise & slot_vld_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
            slot_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                state_q[i]     <= ST_IDLE;
                hold_q[i]      <= '0;
                slot_type_q[i] <= '0;
                mem_q[i]       <= '0;
            end
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);
            slot_vld_q <= slot_vld_d;
            drop_q     <= drop_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i]     <= state_d[i];
                hold_q[i]      <= hold_d[i];
                slot_type_q[i] <= slot_type_d[i];
            end
            if (push) begin
                mem_q[wr_ptr_q] <= {sel_idx, slot_type_q[sel_idx]};
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign o_valid    = (count_q != 3'd0);
    assign o_evt_btn  = o_valid ? head[3:2] : 2'b00;
    assign o_evt_type = o_valid ? head[1:0] : 2'b00;
    assign o_count    = count_q;
    assign o_drop     = drop_q;
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - self-checking bench for btn_event_arbiter
module tb_btn_event_arbiter;
`ifdef BTN_AUTO_REPEAT_EN
    localparam int AUTO = 1;
`else
    localparam int AUTO = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] lvl = 4'b0;
    logic       rdy = 1'b0;
    logic       o_valid;
    logic [1:0] o_evt_btn;
    logic [1:0] o_evt_type;
    logic [2:0] o_count;
    logic       o_drop;

    int checks   = 0;
    int failures = 0;

    btn_event_arbiter #(.F_COUNT(10), .LONG_TICKS(5), .REPEAT_TICKS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_btn_lvl (lvl),
        .i_ready   (rdy),
        .o_valid   (o_valid),
        .o_evt_btn (o_evt_btn),
        .o_evt_type(o_evt_type),
        .o_count   (o_count),
        .o_drop    (o_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] lvl;
        logic       rdy;
        logic       v;
        logic [1:0] b;
        logic [1:0] t;
        logic [2:0] c;
        logic       d;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic [3:0] l, input logic r, input logic v,
                                input logic [1:0] b, input logic [1:0] t,
                                input logic [2:0] c, input logic d);
        vec_t x;
        x.lvl = l; x.rdy = r; x.v = v; x.b = b; x.t = t; x.c = c; x.d = d;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_count"}, o_count, 0);
        chk({tag, "_btn"},   o_evt_btn, 0);
        chk({tag, "_type"},  o_evt_type, 0);
        chk({tag, "_drop"},  o_drop, 0);
    endtask

    logic any_valid;

    initial begin
        // row k is driven before edge k+1 after reset release and checked just after it
        tbl[0]  = mk(4'b0000, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(4'b0010, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(4'b0000, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(4'b0000, 0, 1, 1, 1, 1, 0);
        tbl[4]  = mk(4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(4'b1001, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(4'b0000, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(4'b0000, 0, 1, 0, 1, 1, 0);
        tbl[8]  = mk(4'b0000, 0, 1, 0, 1, 2, 0);
        tbl[9]  = mk(4'b0000, 1, 1, 3, 1, 1, 0);
        tbl[10] = mk(4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[11] = mk(4'b1111, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(4'b0000, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(4'b0000, 0, 1, 0, 1, 1, 0);
        tbl[14] = mk(4'b0011, 0, 1, 0, 1, 2, 0);
        tbl[15] = mk(4'b0000, 0, 1, 0, 1, 3, 0);
        tbl[16] = mk(4'b0001, 0, 1, 0, 1, 4, 0);
        tbl[17] = mk(4'b0010, 0, 1, 0, 1, 4, 0);
        tbl[18] = mk(4'b0000, 0, 1, 0, 1, 4, 1);
        tbl[19] = mk(4'b0000, 0, 1, 0, 1, 4, 0);
        tbl[20] = mk(4'b0000, 1, 1, 1, 1, 4, 0);
        tbl[21] = mk(4'b0000, 1, 1, 2, 1, 4, 0);
        tbl[22] = mk(4'b0000, 1, 1, 0, 1, 4, 0);
        tbl[23] = mk(4'b0000, 1, 1, 0, 1, 3, 0);
        tbl[24] = mk(4'b0000, 1, 1, 1, 1, 2, 0);
        tbl[25] = mk(4'b0000, 1, 1, 3, 1, 1, 0);
        tbl[26] = mk(4'b0000, 1, 0, 0, 0, 0, 0);

        #2;
        chk_idle("in_reset");
        do_reset();
        chk_idle("after_reset");

        for (int i = 0; i < 27; i++) begin
            lvl = tbl[i].lvl;
            rdy = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d_valid", i), o_valid,    tbl[i].v);
            chk($sformatf("vec%0d_btn", i),   o_evt_btn,  tbl[i].b);
            chk($sformatf("vec%0d_type", i),  o_evt_type, tbl[i].t);
            chk($sformatf("vec%0d_count", i), o_count,    tbl[i].c);
            chk($sformatf("vec%0d_drop", i),  o_drop,     tbl[i].d);
        end

        // btn1 held from reset release across three ticks, then released
        do_reset();
        lvl = 4'b0010;
        rdy = 1'b1;
        any_valid = 1'b0;
        repeat (30) begin
            step();
            any_valid |= o_valid;
        end
        chk("short_quiet", any_valid, 0);
        lvl = 4'b0000;
        step();
        chk("short_e31_valid", o_valid, 0);
        step();
        chk("short_e32_valid", o_valid, 1);
        chk("short_e32_btn", o_evt_btn, 1);
        chk("short_e32_type", o_evt_type, 1);
        chk("short_e32_count", o_count, 1);
        step();
        chk("short_e33_valid", o_valid, 0);
        chk("short_e33_count", o_count, 0);

        // btn2 held for nine ticks, consumer stalled
        do_reset();
        lvl = 4'b0100;
        rdy = 1'b0;
        repeat (50) step();
        chk("long_e50_valid", o_valid, 0);
        step();
        chk("long_e51_valid", o_valid, 1);
        chk("long_e51_btn", o_evt_btn, 2);
        chk("long_e51_type", o_evt_type, 2);
        chk("long_e51_count", o_count, 1);
        repeat (20) step();
        chk("held_e71_count", o_count, AUTO ? 2 : 1);
        repeat (19) step();
        lvl = 4'b0000;
        repeat (5) step();
        chk("held_e95_count", o_count, AUTO ? 3 : 1);
        chk("held_e95_head", o_evt_type, 2);
        rdy = 1'b1;
        step();
`ifdef BTN_AUTO_REPEAT_EN
        chk("rep1_btn", o_evt_btn, 2);
        chk("rep1_type", o_evt_type, 3);
        step();
        chk("rep2_type", o_evt_type, 3);
        chk("rep2_count", o_count, 1);
        step();
`endif
        chk("held_drain_valid", o_valid, 0);
        chk("held_drain_count", o_count, 0);

        // reset asserted with two queued events while btn0 is mid-hold
        do_reset();
        rdy = 1'b0;
        lvl = 4'b0011;
        step();
        lvl = 4'b0001;
        step();
        lvl = 4'b1001;
        step();
        lvl = 4'b0001;
        step();
        step();
        chk("mid_count", o_count, 2);
        repeat (15) step();
        chk("mid_e20_count", o_count, 2);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("async_reset");
        lvl = 4'b0000;
        repeat (3) step();
        rst = 1'b1;
        any_valid = 1'b0;
        repeat (70) begin
            step();
            any_valid |= o_valid | o_drop;
        end
        chk("post_reset_quiet", any_valid, 0);
        chk("post_reset_count", o_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/btn_event_arbiter.md
BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 The block SHALL have parameter F_COUNT, default 100_000, giving clk cycles per sample tick (1 ms at 100 MHz).
REQ-002 The block SHALL have parameter LONG_TICKS, default 1000, giving the ticks held before a LONG event.
REQ-003 The block SHALL have parameter REPEAT_TICKS, default 200, giving the ticks between REPEAT events.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_btn_lvl, input, 4 bits: debounced button levels, 1 = pressed, synchronous to clk.
REQ-007 The block SHALL have port i_ready, input, 1 bit: consumer accepts the head event.
REQ-008 The block SHALL have port o_valid, output, 1 bit: the event FIFO is non-empty.
REQ-009 The block SHALL have port o_evt_btn, output, 2 bits: button index of the head event.
REQ-010 The block SHALL have port o_evt_type, output, 2 bits: head event type, 01 SHORT, 10 LONG, 11 REPEAT.
REQ-011 The block SHALL have port o_count, output, 3 bits: FIFO occupancy, 0..4.
REQ-012 The block SHALL have port o_drop, output, 1 bit: one-cycle pulse when an event is lost.

Function
REQ-013 The tick counter SHALL count 0..F_COUNT-1 and wrap to 0; tick SHALL be high for one cycle when count = F_COUNT-1.
REQ-014 Each button SHALL have its own FSM with states IDLE, PRESSED and HELD, plus a hold counter sized by $clog2(LONG_TICKS+1).
REQ-015 In IDLE with level 1, the FSM SHALL go to PRESSED and clear its hold counter.
REQ-016 In PRESSED with level 0, the FSM SHALL raise a SHORT event and go to IDLE.
REQ-017 In PRESSED, each tick SHALL increment the hold counter.
REQ-018 In PRESSED, the tick that brings the hold counter to LONG_TICKS SHALL raise a LONG event, go to HELD and clear the hold counter.
REQ-019 In PRESSED, if release and the LONG_TICKS tick occur in the same cycle, release SHALL win and only SHORT SHALL be raised.
REQ-020 In HELD with level 0, the FSM SHALL go to IDLE with no event.
REQ-021 Each button SHALL have a one-entry pending slot holding a valid flag and the event type; a raised event SHALL set the slot on the same clock edge.
REQ-022 An event raised while that button's slot is already valid SHALL be discarded, SHALL pulse o_drop, and SHALL leave the slot unchanged.
REQ-023 Each cycle the arbiter SHALL move at most one valid slot into the FIFO, choosing the lowest button index first, and SHALL clear that slot.
REQ-024 The FIFO SHALL be 4 deep and first-in first-out.
REQ-025 A FIFO push SHALL be allowed when o_count < 4, or when o_count = 4 and a pop occurs in the same cycle.
REQ-026 A pop SHALL occur when o_valid = 1 and i_ready = 1; i_ready while empty SHALL have no effect.
REQ-027 Pointers SHALL wrap modulo 4.
REQ-028 On a simultaneous push and pop, o_count SHALL be unchanged.
REQ-029 Latency SHALL be as follows: an event raised at edge E enters the slot at E, is written to the FIFO at E+1, and o_valid is high after E+1 when no higher-priority slot is valid and the FIFO is not full.
REQ-030 o_evt_btn and o_evt_type SHALL be driven from the FIFO head entry and SHALL be held stable while o_valid = 1 and i_ready = 0.

Reset
REQ-031 On rst = 0, the tick counter SHALL reset to 0, all FSMs to IDLE, all hold counters to 0 and all slots to invalid.
REQ-032 On rst = 0, the FIFO SHALL empty, with o_valid = 0, o_count = 0, o_evt_btn = 0, o_evt_type = 00 and o_drop = 0.
REQ-033 A button held at reset release SHALL go to PRESSED on the first clock edge, and its hold count SHALL start from 0.
REQ-034 Reset asserted mid-press SHALL discard all pending and queued events.

Configuration
REQ-035 With macro BTN_AUTO_REPEAT_EN defined, in HELD each tick SHALL increment the hold counter.
REQ-036 With BTN_AUTO_REPEAT_EN defined, the tick that brings the hold counter to REPEAT_TICKS SHALL raise a REPEAT event and clear the counter.
REQ-037 With BTN_AUTO_REPEAT_EN defined, REPEAT events SHALL obey the slot and drop rules of REQ-021 and REQ-022.
REQ-038 Without BTN_AUTO_REPEAT_EN, HELD SHALL raise no events, the REPEAT logic SHALL be absent, and type 11 SHALL never appear.

Verification
All scenarios use F_COUNT=10, LONG_TICKS=5, REPEAT_TICKS=2.
REQ-039 Press btn1 for 3 ticks then release, with i_ready=1 -> one event {btn=1, type=01}, o_valid high 2 cycles after the release edge, o_count back to 0.
REQ-040 Hold btn2 for 8 ticks with the macro undefined -> exactly one {2, 10} at the 5th tick, and nothing on release.
REQ-041 Hold btn2 for 9 ticks with the macro defined -> {2, 10} at tick 5, then {2, 11} at ticks 7 and 9.
REQ-042 Release btn0 and btn3 in the same cycle -> {0, 01} is queued before {3, 01} in consecutive cycles.
REQ-043 With i_ready=0, produce 6 SHORT events on btn0..btn3 -> o_count saturates at 4, slots hold the rest, o_drop pulses on a same-button repeat, then raising i_ready drains in order.
REQ-044 Assert rst mid-hold with o_count=2 -> all outputs return to reset values immediately, and no LONG event is produced after release.
